// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and lane helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
  localparam logic [2:0] LD_LB = 3'b000, LD_LH = 3'b001, LD_LW = 3'b010, LD_LBU = 3'b011, LD_LHU = 3'b100;
  localparam logic [1:0] ST_SB = 2'b00, ST_SH = 2'b01, ST_SW = 2'b10;
  localparam logic [1:0] SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2;
  function automatic logic [1:0] ld_size(input logic [2:0] ld);
    return (ld == LD_LB || ld == LD_LBU) ? SZ_B : (ld == LD_LH || ld == LD_LHU) ? SZ_H : SZ_W;
  endfunction
  function automatic logic [1:0] st_size(input logic [1:0] st);
    return st == ST_SB ? SZ_B : st == ST_SH ? SZ_H : SZ_W;
  endfunction
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    return sz == SZ_B ? 4'b0001 << off : sz == SZ_H ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
  endfunction
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    return sz == SZ_B ? {4{wd[7:0]}} : sz == SZ_H ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: extracts and sign/zero-extends a byte, half or word from a memory word
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  load_i,
  output logic [31:0] data_o
);
  logic [31:0] b, h;
  assign b = word_i >> {off_i, 3'b000};
  assign h = word_i >> {off_i[1], 4'b0000};
  assign data_o = load_i == LD_LB  ? {{24{b[7]}}, b[7:0]} :
                  load_i == LD_LH  ? {{16{h[15]}}, h[15:0]} :
                  load_i == LD_LBU ? {24'b0, b[7:0]} :
                  load_i == LD_LHU ? {16'b0, h[15:0]} : word_i;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle req/ack data-memory access stage with fault reporting
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Store,
  input  logic [2:0]  Load,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Done,
  output logic        MisalignFault,
  output logic        BusFault,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  output logic [3:0]  DMemBe,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData
);
  state_t state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, cnt_q, cnt_d, aligned;
  logic [3:0] be_q;
  logic [2:0] ld_q;
  logic we_q, mis_q, bus_q, access, mis, tmo;
  logic [1:0] sz;
  assign access = MemRead | MemWrite;
  assign sz = MemWrite ? st_size(Store) : ld_size(Load);
  assign mis = (sz == SZ_H && Addr[0]) || (sz == SZ_W && Addr[1:0] != 2'b00);
  assign tmo = (ACK_TIMEOUT != 0) && (cnt_q + 32'd1 == 32'(ACK_TIMEOUT));
  load_align u_align (.word_i(DMemRData), .off_i(addr_q[1:0]), .load_i(ld_q), .data_o(aligned));
  // state and timeout counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // next state: accept in IDLE, wait for ack or timeout in REQ, single DONE cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (access) begin
        state_d = mis ? S_DONE : S_REQ;
        cnt_d   = '0;
      end
      S_REQ: if (DMemAck) state_d = S_DONE;
      else begin
        cnt_d   = cnt_q + 32'd1;
        state_d = tmo ? S_DONE : S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end
  // access capture, fault flags and registered load result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      ld_q    <= '0;
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      bus_q   <= 1'b0;
    end else if (state_q == S_IDLE && access) begin
      addr_q  <= Addr;
      wdata_q <= lane_wdata(sz, WriteData);
      be_q    <= lane_be(sz, Addr[1:0]);
      ld_q    <= Load;
      we_q    <= MemWrite;
      mis_q   <= mis;
      bus_q   <= 1'b0;
      if (mis) rdata_q <= '0;
    end else if (state_q == S_REQ && DMemAck) begin
      if (!we_q) rdata_q <= aligned;
    end else if (state_q == S_REQ && tmo) begin
      bus_q   <= 1'b1;
      rdata_q <= '0;
    end
  end
  assign Stall         = (state_q == S_IDLE && access) || state_q == S_REQ;
  assign Done          = state_q == S_DONE;
  assign MisalignFault = Done && mis_q;
  assign BusFault      = Done && bus_q;
  assign DMemReq       = state_q == S_REQ;
  assign DMemWe        = DMemReq && we_q;
  assign DMemAddr      = {addr_q[31:2], 2'b00};
  assign DMemWData     = wdata_q;
  assign DMemBe        = be_q;
  assign ReadData      = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: vector-table and scoreboard bench for the load/store unit
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic MemRead = 1'b0, MemWrite = 1'b0, DMemAck = 1'b0;
  logic [1:0] Store = 2'b00;
  logic [2:0] Load = 3'b000;
  logic [31:0] Addr = '0, WriteData = '0, DMemRData = '0;
  logic Stall, Done, MisalignFault, BusFault, DMemReq, DMemWe;
  logic [31:0] ReadData, DMemAddr, DMemWData;
  logic [3:0] DMemBe;
  int checks = 0, errors = 0, cyc = 0;

  typedef struct {
    logic rd; logic wr; logic [1:0] st; logic [2:0] ld;
    logic [31:0] addr; logic [31:0] wd; logic [31:0] rdata; int dly;
    logic [3:0] be; logic [31:0] bwd; logic [31:0] rd_exp; logic mis; logic bus;
  } vec_t;
  typedef struct { logic [31:0] rd; logic mis; logic bus; int start; int lat; } exp_t;
  vec_t tv[17];
  exp_t sb[$];

  load_store_unit #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Store(Store), .Load(Load),
    .Addr(Addr), .WriteData(WriteData), .Stall(Stall), .ReadData(ReadData), .Done(Done),
    .MisalignFault(MisalignFault), .BusFault(BusFault), .DMemReq(DMemReq), .DMemWe(DMemWe),
    .DMemAddr(DMemAddr), .DMemWData(DMemWData), .DMemBe(DMemBe), .DMemAck(DMemAck), .DMemRData(DMemRData)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input int idx);
    exp_t e;
    bit seen = 1'b0;
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; Store = v.st; Load = v.ld; Addr = v.addr; WriteData = v.wd;
    e.rd = v.rd_exp; e.mis = v.mis; e.bus = v.bus; e.start = cyc;
    e.lat = v.mis ? 2 : (v.dly < 0 ? TO + 2 : v.dly + 3);
    sb.push_back(e);
    #1;
    chk($sformatf("v%0d_stall_accept", idx), {31'b0, Stall}, 32'd1);
    chk($sformatf("v%0d_req_idle", idx), {31'b0, DMemReq}, 32'd0);
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      if (Done) seen = 1'b1;
      else begin
        chk($sformatf("v%0d_req", idx), {31'b0, DMemReq}, 32'd1);
        chk($sformatf("v%0d_stall_req", idx), {31'b0, Stall}, 32'd1);
        chk($sformatf("v%0d_addr", idx), DMemAddr, v.addr & 32'hFFFF_FFFC);
        chk($sformatf("v%0d_be", idx), {28'b0, DMemBe}, {28'b0, v.be});
        chk($sformatf("v%0d_we", idx), {31'b0, DMemWe}, {31'b0, v.wr});
        if (v.wr) chk($sformatf("v%0d_wdata", idx), DMemWData, v.bwd);
        DMemAck = v.dly >= 0 && n >= v.dly;
        DMemRData = v.rdata;
      end
    end
    DMemAck = 1'b0;
    e = sb.pop_front();
    if (!seen) begin
      checks++; errors++;
      $display("FAIL v%0d_done_timeout got no Done want Done", idx);
    end else begin
      chk($sformatf("v%0d_latency", idx), cyc - e.start + 1, e.lat);
      chk($sformatf("v%0d_rdata", idx), ReadData, e.rd);
      chk($sformatf("v%0d_misalign", idx), {31'b0, MisalignFault}, {31'b0, e.mis});
      chk($sformatf("v%0d_busfault", idx), {31'b0, BusFault}, {31'b0, e.bus});
      chk($sformatf("v%0d_req_done", idx), {31'b0, DMemReq}, 32'd0);
      chk($sformatf("v%0d_stall_done", idx), {31'b0, Stall}, 32'd0);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_done_clear", idx), {31'b0, Done}, 32'd0);
    chk($sformatf("v%0d_stall_idle", idx), {31'b0, Stall}, 32'd0);
    chk($sformatf("v%0d_rdata_hold", idx), ReadData, e.rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got hang want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         rd   wr    st     ld      addr          wd            rdata       dly  be       bwd           rd_exp        mis   bus
    tv[0]  = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h1003, 32'h0,        32'h80FF1234, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 2'b00, 3'b100, 32'h2002, 32'h0,        32'h9ABC5678, 3, 4'b1100, 32'h0,        32'h00009ABC, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b1, 2'b01, 3'b000, 32'h0006, 32'h1234ABCD, 32'hFFFFFFFF, 0, 4'b1100, 32'hABCDABCD, 32'h00009ABC, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 2'b00, 3'b001, 32'h0000, 32'h0,        32'h00008001, 1, 4'b0011, 32'h0,        32'hFFFF8001, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0010, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    tv[5]  = '{1'b0, 1'b1, 2'b00, 3'b000, 32'h0001, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 2'b00, 3'b011, 32'h0002, 32'h0,        32'h11C32211, 2, 4'b0100, 32'h0,        32'h000000C3, 1'b0, 1'b0};
    tv[7]  = '{1'b0, 1'b1, 2'b10, 3'b000, 32'h0005, 32'h00000001, 32'h0,        0, 4'b0000, 32'h0,        32'h00000000, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0020, 32'h0,        32'h55AA55AA, 0, 4'b1111, 32'h0,        32'h55AA55AA, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0100, 32'h0,        32'h12345678, -1, 4'b1111, 32'h0,       32'h00000000, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b1, 2'b00, 3'b010, 32'h0003, 32'h0000007E, 32'h0,        0, 4'b1000, 32'h7E7E7E7E, 32'h00000000, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0004, 32'h0,        32'h12345678, 0, 4'b1111, 32'h0,        32'h12345678, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b0, 2'b00, 3'b001, 32'h0001, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h00000000, 1'b1, 1'b0};
    tv[13] = '{1'b1, 1'b0, 2'b00, 3'b111, 32'h0008, 32'h0,        32'hCAFEF00D, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
    tv[14] = '{1'b0, 1'b1, 2'b11, 3'b000, 32'h000C, 32'h87654321, 32'h0,        0, 4'b1111, 32'h87654321, 32'hCAFEF00D, 1'b0, 1'b0};
    tv[15] = '{1'b1, 1'b0, 2'b00, 3'b000, 32'h0001, 32'h0,        32'h00007F00, 0, 4'b0010, 32'h0,        32'h0000007F, 1'b0, 1'b0};
    tv[16] = '{1'b1, 1'b0, 2'b00, 3'b010, 32'h0002, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h00000000, 1'b1, 1'b0};
    repeat (2) @(negedge clk);
    chk("reset_stall", {31'b0, Stall}, 32'd0);
    chk("reset_done", {31'b0, Done}, 32'd0);
    chk("reset_req", {31'b0, DMemReq}, 32'd0);
    chk("reset_rdata", ReadData, 32'd0);
    chk("reset_addr", DMemAddr, 32'd0);
    chk("reset_wdata", DMemWData, 32'd0);
    chk("reset_be", {28'b0, DMemBe}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) run(tv[i], i);
    @(negedge clk);
    DMemAck = 1'b1; DMemRData = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_ack_done", {31'b0, Done}, 32'd0);
    chk("idle_ack_req", {31'b0, DMemReq}, 32'd0);
    chk("idle_ack_rdata", ReadData, 32'd0);
    DMemAck = 1'b0;
    MemRead = 1'b1; Load = 3'b010; Addr = 32'h0000_0040;
    @(negedge clk);
    chk("rst_mid_req_before", {31'b0, DMemReq}, 32'd1);
    chk("rst_mid_addr_before", DMemAddr, 32'h0000_0040);
    #2 reset = 1'b1; MemRead = 1'b0;
    #1;
    chk("rst_mid_req", {31'b0, DMemReq}, 32'd0);
    chk("rst_mid_stall", {31'b0, Stall}, 32'd0);
    chk("rst_mid_addr", DMemAddr, 32'd0);
    chk("rst_mid_be", {28'b0, DMemBe}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rel_req", {31'b0, DMemReq}, 32'd0);
    chk("rst_rel_done", {31'b0, Done}, 32'd0);
    chk("rst_rel_stall", {31'b0, Stall}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access stage, directly downstream of the main decoder.
- Consumes the decoder's MemWrite, Store[1:0] and Load[2:0] controls plus MemRead (asserted when ResultSrc=01), the ALU address and the rs2 data.
- Drives a req/ack data-memory port with byte enables and returns sign/zero-extended load data.
- Stalls the core until the access completes; flags misaligned accesses and bus timeouts.

Parameters:
- ACK_TIMEOUT, 255: maximum REQ cycles waiting for DMemAck before BusFault; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- MemRead  in  1  load instruction present
- MemWrite  in  1  store instruction present
- Store  in  2  00 sb, 01 sh, 10 sw
- Load  in  3  000 lb, 001 lh, 010 lw, 011 lbu, 100 lhu
- Addr  in  32  effective byte address (ALU result)
- WriteData  in  32  store data (rs2)
- Stall  out  1  hold PC/pipeline this cycle
- ReadData  out  32  extended load result, valid when Done=1
- Done  out  1  one-cycle completion pulse
- MisalignFault  out  1  with Done: access was misaligned
- BusFault  out  1  with Done: ack timeout
- DMemReq  out  1  memory request, held until ack
- DMemWe  out  1  write request
- DMemAddr  out  32  word address {Addr[31:2],2'b00}
- DMemWData  out  32  lane-replicated store data
- DMemBe  out  4  byte enables
- DMemAck  in  1  memory accepted/completed request
- DMemRData  in  32  read word, valid with DMemAck

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs 0, including ReadData, DMemAddr, DMemWData, DMemBe. Timeout counter 0.
- States: IDLE, REQ, DONE.
- IDLE, with access = MemRead|MemWrite:
  - If access: register Addr, WriteData, size, sign and write flag. Stall=1 combinationally.
  - If aligned, next state is REQ. If misaligned, next state is DONE with MisalignFault; no bus request is issued.
  - If no access: Stall=0.
- MemRead and MemWrite both high: MemWrite wins; the access is a store.
- Misaligned (both loads and stores):
  - half access (sh/lh/lhu) with Addr[0]=1;
  - word access (sw/lw) with Addr[1:0]≠0.
- REQ:
  - DMemReq=1, Stall=1. All DMem* outputs are driven from registers and stay stable until ack.
  - On DMemAck: capture DMemRData (reads) and go to DONE.
  - The counter increments on each REQ cycle without ack. When it reaches ACK_TIMEOUT: go to DONE, BusFault=1, ReadData=0.
- DONE:
  - Stall=0, Done=1 for exactly one cycle, DMemReq=0. Next state is IDLE unconditionally; DONE never re-accepts.
  - The core advances at the end of the DONE cycle, so the next instruction is seen in IDLE.
  - Fault flags are valid only in DONE.
- Byte enables:
  - sb: 0001<<Addr[1:0]
  - sh: 0011<<{Addr[1],1'b0}
  - sw: 1111
  - Reads drive the same lane pattern for the access size.
- DMemWData:
  - sb: {4{WriteData[7:0]}}
  - sh: {2{WriteData[15:0]}}
  - sw: WriteData
- Load extraction:
  - byte = word >> (Addr[1:0]*8)[7:0]; half = word >> (Addr[1]*16)[15:0].
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - Load 101–111 behaves as lw; Store 11 behaves as sw.
- ReadData is registered; it holds its value after DONE until the next completed load.
  - Stores leave ReadData unchanged.
  - Faults set ReadData to 0.
- Latency: accept cycle + n REQ cycles (n≥1) + DONE. Minimum 3 cycles with ack in the first REQ cycle.
- Reset during REQ: DMemReq drops immediately. The memory side must tolerate an abandoned request.
- DMemAck while not in REQ is ignored.

Decomposition:
- Shared package (lsu_pkg) holds:
  - Load/Store encodings: LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU, ST_SB, ST_SH, ST_SW;
  - state constants S_IDLE, S_REQ, S_DONE.
- One combinational sub-module, load_align: word + Addr[1:0] + Load in, extended 32-bit value out. It is reused by the register-file writeback mux.
- The FSM, lane generation and timeout counter live in load_store_unit.

Test Plan:
- lb, Addr=0x1003, DMemRData=0x80FF_1234, ack in first REQ cycle:
  - DMemAddr=0x1000, DMemBe=1000, Stall high 2 cycles;
  - Done on cycle 3, ReadData=0xFFFF_FF80.
- lhu, Addr=0x2002, DMemRData=0x9ABC_5678, ack after 4 REQ cycles: ReadData=0x0000_9ABC, Done on cycle 6.
- sh, Addr=0x0006, WriteData=0x1234_ABCD: DMemWe=1, DMemBe=1100, DMemWData=0xABCD_ABCD; ReadData unchanged.
- sw, Addr=0x0005: DMemReq never asserts; Done+MisalignFault on cycle 2; next cycle IDLE.
- ACK_TIMEOUT=4, lw, DMemAck held 0: after 4 REQ cycles DONE with BusFault=1, ReadData=0.
- MemRead=MemWrite=1 → store performed. Reset asserted mid-REQ → DMemReq=0 the same cycle; all outputs 0; IDLE after release.
